// File: rtl/mem_arbiter.sv
// Shares one external memory port between I-cache refills and D-cache bursts.
// The D-cache normally wins; a starvation counter eventually forces an I-cache grant.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wnext,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int BEAT_W   = $clog2(LINE_WORDS);
    localparam int OFF      = BEAT_W + 2;
    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_t;

    state_t              state_reg, state_next;
    logic [BEAT_W-1:0]   beat_reg, beat_next;
    logic [STARVE_W-1:0] starve_reg, starve_next;
    logic [ADDR_W-1:0]   owner_addr;
    logic                last_beat;
    logic                unused_addr_bits;

    // Offset bits within a line are replaced by the beat counter.
    assign unused_addr_bits = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            beat_reg   <= '0;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            beat_reg   <= beat_next;
            starve_reg <= starve_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        beat_next   = beat_reg;
        starve_next = starve_reg;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_rvalid    = 1'b0;
        i_done      = 1'b0;
        d_rvalid    = 1'b0;
        d_done      = 1'b0;
        d_wnext     = 1'b0;
        i_rdata     = mem_rdata;
        d_rdata     = mem_rdata;
        owner_addr  = (state_reg == GNT_D) ? d_addr : i_addr;
        last_beat   = mem_ready && (beat_reg == LAST_BEAT);

        unique case (state_reg)
            IDLE: begin
                if (d_req && !(i_req && starve_reg == STARVE_LIM)) begin
                    state_next = GNT_D;
                    // Below the limit here whenever i_req is set, so no overflow.
                    if (i_req)
                        starve_next = starve_reg + STARVE_W'(1);
                end else if (i_req) begin
                    state_next  = GNT_I;
                    starve_next = '0;
                end
            end
            GNT_I, GNT_D: begin
                mem_req   = 1'b1;
                mem_addr  = {owner_addr[ADDR_W-1:OFF], beat_reg, 2'b00};
                mem_wdata = d_wdata;
                if (state_reg == GNT_D) begin
                    mem_we   = d_we;
                    d_rvalid = mem_ready && !d_we;
                    d_wnext  = mem_ready && d_we;
                    d_done   = last_beat;
                end else begin
                    i_rvalid = mem_ready;
                    i_done   = last_beat;
                end
                if (mem_ready)
                    beat_next = beat_reg + BEAT_W'(1);
                if (last_beat)
                    state_next = RELEASE;
            end
            RELEASE: begin
                // Gives the finished owner one cycle to drop its request.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
